freq_meter: RTL

- Measures the frequency of a slow or asynchronous input signal, `sig_in`, by counting its rising edges over a fixed gate window of reference-clock cycles.
- Performs the inverse of the team's prescaler: that block makes a slow clock from `clk`; this block recovers the rate of a slow signal in `clk` cycles.
- Used to self-check divider outputs, and to read external pulse sources (buttons, sensors) on the DE10 board.
- The result feeds display or compare logic through a one-cycle valid strobe.

---
 rtl/freq_meter_pkg.sv | 13 +
 rtl/edge_sync.sv | 31 +++
 rtl/freq_meter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and default constants for the frequency meter.
// Pure declarations: no logic, no latency, no flow control.
package freq_meter_pkg;

    localparam int CLK_HZ         = 50_000_000;
    localparam int GATE_CYCLES_1S = CLK_HZ;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous input and flags its rising edges as a one-cycle pulse.
// Latency SYNC_STAGES+1 clocks from input edge to counted rise; no backpressure.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_in,
    output logic rise
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("edge_sync: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev   <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over back-to-back GATE_CYCLES windows of clk.
// Result publishes one clock after window end with a count_valid strobe; no backpressure.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_WIDTH  = 26,
    parameter int GATE_CYCLES = GATE_CYCLES_1S,
    parameter int COUNT_WIDTH = 26,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   sig_in,
    output logic [COUNT_WIDTH-1:0] freq_count,
    output logic                   count_valid,
    output logic                   overflow,
    output logic                   busy
);

    if (GATE_CYCLES < 2 || GATE_CYCLES >= (64'd1 << GATE_WIDTH)) begin : g_bad_gate
        $error("freq_meter: GATE_CYCLES must be >= 2 and fit in GATE_WIDTH bits");
    end

    localparam logic [GATE_WIDTH-1:0]  GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    state_t                 state;
    state_t                 state_nxt;
    logic [GATE_WIDTH-1:0]  gate_cnt;
    logic [GATE_WIDTH-1:0]  gate_cnt_nxt;
    logic [COUNT_WIDTH-1:0] edge_cnt;
    logic [COUNT_WIDTH-1:0] edge_cnt_nxt;
    logic                   ovf;
    logic                   ovf_nxt;
    logic                   rise;
    logic                   edge_sat;
    logic                   window_end;
    logic                   publish;
    logic [COUNT_WIDTH-1:0] cnt_acc;
    logic                   ovf_acc;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_in  (sig_in),
        .rise    (rise)
    );

    // Count including this cycle's rise; serves both the running count and the window result.
    assign edge_sat   = (edge_cnt == COUNT_MAX);
    assign cnt_acc    = edge_sat ? edge_cnt : edge_cnt + COUNT_WIDTH'(rise);
    assign ovf_acc    = ovf | (edge_sat & rise);
    assign window_end = (state == GATE) && (gate_cnt == GATE_LAST);

    always_comb begin
        state_nxt    = state;
        gate_cnt_nxt = gate_cnt;
        edge_cnt_nxt = edge_cnt;
        ovf_nxt      = ovf;
        publish      = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt    = GATE;
                    gate_cnt_nxt = '0;
                    edge_cnt_nxt = '0;
                    ovf_nxt      = 1'b0;
                end
            end
            GATE: begin
                if (window_end) begin
                    publish      = 1'b1;
                    gate_cnt_nxt = '0;
                    edge_cnt_nxt = '0;
                    ovf_nxt      = 1'b0;
                end else begin
                    gate_cnt_nxt = gate_cnt + GATE_WIDTH'(1);
                    edge_cnt_nxt = cnt_acc;
                    ovf_nxt      = ovf_acc;
                end
                // A window ending on the same cycle still publishes before going idle.
                if (!enable) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_nxt;
            gate_cnt <= gate_cnt_nxt;
            edge_cnt <= edge_cnt_nxt;
            ovf      <= ovf_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            freq_count  <= '0;
            overflow    <= 1'b0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= publish;
            if (publish) begin
                freq_count <= cnt_acc;
                overflow   <= ovf_acc;
            end
        end
    end

    assign busy = (state == GATE);

endmodule
